// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the data-memory load/store controller.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Reserved size is reported as misaligned so one check covers every error.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] wmask_of(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << {off[1], 1'b0};
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = mem_rdata[7:0];
    half_sel  = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (offset)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    case (size)
      SZ_B:    load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_H:    load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store controller: one request at a time through IDLE -> ISSUE -> (WAIT) -> RESP,
// driving a 1-cycle-latency byte-masked word memory from registered outputs.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] wdata_rep;

  lsu_load_align u_align (
    .mem_rdata   (mem_rdata),
    .size        (size_q),
    .offset      (off_q),
    .is_unsigned (uns_q),
    .load_data   (load_data)
  );

  always_comb begin
    case (req_size)
      SZ_B:    wdata_rep = {4{req_wdata[7:0]}};
      SZ_H:    wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
    we_d        = we_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d      = req_size;
          off_d       = req_addr[1:0];
          uns_d       = req_unsigned;
          we_d        = req_we;
          rsp_rdata_d = '0;
          if (misaligned(req_size, req_addr[1:0])) begin
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end else begin
            rsp_err_d   = 1'b0;
            mem_addr_d  = req_addr[ADDR_W-1:2];
            mem_wdata_d = wdata_rep;
            mem_wmask_d = req_we ? wmask_of(req_size, req_addr[1:0]) : 4'b0000;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // The memory samples the mask at this edge; dropping it guarantees a single write.
        mem_wmask_d = 4'b0000;
        state_d     = we_q ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        rsp_rdata_d = load_data;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= 4'b0000;
      size_q      <= SZ_B;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

endmodule
